// File: rtl/ex3_bcd_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ex3_bcd_seq_decoder
// Description : Excess-3 to BCD decoder with sequence tracking. Decodes one
//               excess-3 digit per valid cycle, flags illegal codes, and
//               checks the stream against an ascending mod-10 count,
//               reporting lock, sequence breaks and 9->0 decade wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module ex3_bcd_seq_decoder #(
  parameter int LOCK_CNT = 3,  // consecutive good steps needed to lock (1..15)
  parameter int CNT_W    = 8   // width of the wrap counter
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic [3:0]       q,
  output logic             out_valid,
  output logic             code_err,
  output logic             seq_locked,
  output logic             seq_err,
  output logic [CNT_W-1:0] wrap_cnt
);

  localparam logic [3:0] C_LOCK_CNT = LOCK_CNT[3:0];

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       q_q, q_d;
  logic             out_valid_q, out_valid_d;
  logic             code_err_q, code_err_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [3:0] w_code;
  logic       w_legal;
  logic [3:0] w_digit;
  logic [3:0] w_expected;
  logic       w_match;
  logic [3:0] w_good_inc;
  logic       w_wrap_sat;

  // Decode the incoming code and compare it against the next expected digit
  always_comb begin
    w_code     = {w, x, y, z};
    w_legal    = (w_code >= 4'd3) && (w_code <= 4'd12);
    w_digit    = w_code - 4'd3;
    w_expected = (prev_q == 4'd9) ? 4'd0 : (prev_q + 4'd1);
    w_match    = (w_digit == w_expected);
    w_good_inc = good_cnt_q + 4'd1;
    w_wrap_sat = &wrap_cnt_q;
  end

  // Next-state and registered-output logic for the HUNT/LOCK tracker
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    q_d         = q_q;
    out_valid_d = 1'b0;
    code_err_d  = 1'b0;
    seq_err_d   = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;

    if (in_valid) begin
      if (w_legal) begin
        q_d         = w_digit;
        out_valid_d = 1'b1;
      end else begin
        code_err_d  = 1'b1;
      end

      case (state_q)
        HUNT: begin
          if (w_legal) begin
            prev_d      = w_digit;
            have_prev_d = 1'b1;
            if (have_prev_q && w_match) begin
              good_cnt_d = w_good_inc;
              if (w_good_inc == C_LOCK_CNT) begin
                state_d = LOCK;
              end
            end else begin
              good_cnt_d = 4'd0;
            end
          end else begin
            good_cnt_d  = 4'd0;
            have_prev_d = 1'b0;
          end
        end

        LOCK: begin
          if (w_legal && w_match) begin
            prev_d = w_digit;
            // A decade rollover seen while locked; counter sticks at max
            if ((prev_q == 4'd9) && !w_wrap_sat) begin
              wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
          end else if (w_legal) begin
            seq_err_d   = 1'b1;
            state_d     = HUNT;
            good_cnt_d  = 4'd0;
            prev_d      = w_digit;
            have_prev_d = 1'b1;
          end else begin
            seq_err_d   = 1'b1;
            state_d     = HUNT;
            good_cnt_d  = 4'd0;
            have_prev_d = 1'b0;
          end
        end

        default: begin
          state_d    = HUNT;
          good_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      good_cnt_q  <= 4'd0;
      have_prev_q <= 1'b0;
      prev_q      <= 4'd0;
      q_q         <= 4'd0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign q          = q_q;
  assign out_valid  = out_valid_q;
  assign code_err   = code_err_q;
  assign seq_locked = (state_q == LOCK);
  assign seq_err    = seq_err_q;
  assign wrap_cnt   = wrap_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex3_bcd_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex3_bcd_seq_decoder
// Description : Directed self-checking bench for ex3_bcd_seq_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex3_bcd_seq_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       w, x, y, z;
  logic [3:0] q;
  logic       out_valid;
  logic       code_err;
  logic       seq_locked;
  logic       seq_err;
  logic [7:0] wrap_cnt;

  int n_checks;
  int n_errors;
  int n_step;

  ex3_bcd_seq_decoder #(
    .LOCK_CNT(3),
    .CNT_W   (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .q         (q),
    .out_valid (out_valid),
    .code_err  (code_err),
    .seq_locked(seq_locked),
    .seq_err   (seq_err),
    .wrap_cnt  (wrap_cnt)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic eov,
                         input logic ece, input logic esl, input logic ese,
                         input logic [7:0] ewc);
    chk({tag, "_q"},   32'(q),          32'(eq));
    chk({tag, "_ov"},  32'(out_valid),  32'(eov));
    chk({tag, "_ce"},  32'(code_err),   32'(ece));
    chk({tag, "_sl"},  32'(seq_locked), 32'(esl));
    chk({tag, "_se"},  32'(seq_err),    32'(ese));
    chk({tag, "_wc"},  32'(wrap_cnt),   32'(ewc));
  endtask

  // Present one input cycle, then check outputs 1 ns after the capturing edge
  task automatic step(input logic v, input logic [3:0] e,
                      input logic [3:0] eq, input logic eov, input logic ece,
                      input logic esl, input logic ese, input logic [7:0] ewc);
    in_valid = v;
    {w, x, y, z} = e;
    @(posedge clk);
    #1;
    n_step++;
    chk_all($sformatf("s%0d", n_step), eq, eov, ece, esl, ese, ewc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_step   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    {w, x, y, z} = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Acquire lock: digits 0,1,2,3
    step(1, 4'd3,  4'd0, 1, 0, 0, 0, 8'd0);
    step(1, 4'd4,  4'd1, 1, 0, 0, 0, 8'd0);
    step(1, 4'd5,  4'd2, 1, 0, 0, 0, 8'd0);
    step(1, 4'd6,  4'd3, 1, 0, 1, 0, 8'd0);

    // Continue 4..9 while locked
    for (int i = 4; i <= 9; i++) begin
      step(1, 4'(i + 3), 4'(i), 1, 0, 1, 0, 8'd0);
    end

    // Decade wrap 9->0, then 1
    step(1, 4'd3,  4'd0, 1, 0, 1, 0, 8'd1);
    step(1, 4'd4,  4'd1, 1, 0, 1, 0, 8'd1);

    // Advance to digit 4, then break with 7
    step(1, 4'd5,  4'd2, 1, 0, 1, 0, 8'd1);
    step(1, 4'd6,  4'd3, 1, 0, 1, 0, 8'd1);
    step(1, 4'd7,  4'd4, 1, 0, 1, 0, 8'd1);
    step(1, 4'd10, 4'd7, 1, 0, 0, 1, 8'd1);

    // Relock with 8,9,0; the 9->0 here happens in HUNT and is not counted
    step(1, 4'd11, 4'd8, 1, 0, 0, 0, 8'd1);
    step(1, 4'd12, 4'd9, 1, 0, 0, 0, 8'd1);
    step(1, 4'd3,  4'd0, 1, 0, 1, 0, 8'd1);

    // Illegal code while locked, then illegal code while hunting
    step(1, 4'd14, 4'd0, 0, 1, 0, 1, 8'd1);
    step(1, 4'd13, 4'd0, 0, 1, 0, 0, 8'd1);

    // Valid gaps do not disturb the sequence; illegal pattern on an idle cycle is ignored
    step(1, 4'd5,  4'd2, 1, 0, 0, 0, 8'd1);
    step(0, 4'd0,  4'd2, 0, 0, 0, 0, 8'd1);
    step(1, 4'd6,  4'd3, 1, 0, 0, 0, 8'd1);
    step(0, 4'd15, 4'd3, 0, 0, 0, 0, 8'd1);
    step(1, 4'd7,  4'd4, 1, 0, 0, 0, 8'd1);
    step(1, 4'd8,  4'd5, 1, 0, 1, 0, 8'd1);

    // Run to the next wrap so wrap_cnt reaches 2
    step(1, 4'd9,  4'd6, 1, 0, 1, 0, 8'd1);
    step(1, 4'd10, 4'd7, 1, 0, 1, 0, 8'd1);
    step(1, 4'd11, 4'd8, 1, 0, 1, 0, 8'd1);
    step(1, 4'd12, 4'd9, 1, 0, 1, 0, 8'd1);
    step(1, 4'd3,  4'd0, 1, 0, 1, 0, 8'd2);

    // Asynchronous reset between clock edges
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_all("areset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First digit after release, then relock and break with a repeated digit
    step(1, 4'd8,  4'd5, 1, 0, 0, 0, 8'd0);
    step(1, 4'd9,  4'd6, 1, 0, 0, 0, 8'd0);
    step(1, 4'd10, 4'd7, 1, 0, 0, 0, 8'd0);
    step(1, 4'd11, 4'd8, 1, 0, 1, 0, 8'd0);
    step(1, 4'd11, 4'd8, 1, 0, 0, 1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex3_bcd_seq_decoder.md
Name: ex3_bcd_seq_decoder

Overview:
Receive-side counterpart of the BCD-to-excess-3 sequential counter: accepts one excess-3 digit per cycle on w,x,y,z and returns registered BCD on q. Flags illegal excess-3 codes. Tracks the incoming digit stream against the counter's expected ascending mod-10 sequence. Reports lock, sequence breaks and decade wraps, so a counter output can be checked in-system.

Parameters:
LOCK_CNT, 3, consecutive correct +1 (mod 10) steps required to enter LOCK; legal range 1..15
CNT_W, 8, width of wrap_cnt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  w,x,y,z carry a digit this cycle
w  input  1  excess-3 bit 3 (MSB)
x  input  1  excess-3 bit 2
y  input  1  excess-3 bit 1
z  input  1  excess-3 bit 0 (LSB)
q  output  4  decoded BCD digit, registered
out_valid  output  1  q updated this cycle (1-cycle pulse per legal input)
code_err  output  1  1-cycle pulse: illegal excess-3 code received
seq_locked  output  1  level: FSM in LOCK
seq_err  output  1  1-cycle pulse: digit broke sequence while locked
wrap_cnt  output  CNT_W  count of accepted 9->0 steps while locked, saturating

Behaviour:
- Reset (async, rst_n=0): q=0, out_valid=0, code_err=0, seq_locked=0, seq_err=0, wrap_cnt=0. Internal state: FSM=HUNT, good_cnt=0, have_prev=0, prev=0. Release is sampled synchronously; the first capture is on the first rising edge with rst_n=1.
- Reset asserted mid-stream forces all of the above immediately, regardless of clk.
- Decode: e={w,x,y,z}. Legal iff 3<=e<=12; d=e-3 (4-bit, no wrap needed).
- All outputs are registered: 1-cycle latency from in_valid sample to out_valid/q/code_err/seq_err.
- in_valid=0: no state change; out_valid, code_err and seq_err are 0 next cycle; q holds.
- Legal digit: q<=d, out_valid<=1, code_err<=0.
- Illegal digit (e in 0,1,2,13,14,15): q holds, out_valid<=0, code_err<=1.
- expected = (prev==9) ? 0 : prev+1.
- FSM HUNT:
  - legal and (!have_prev or d!=expected): good_cnt<=0.
  - legal and have_prev and d==expected: good_cnt<=good_cnt+1.
  - If the incremented value equals LOCK_CNT, go to LOCK and set seq_locked<=1 in the same edge.
  - Every legal digit sets prev<=d and have_prev<=1.
  - Illegal: good_cnt<=0, have_prev<=0, no seq_err.
- FSM LOCK:
  - legal and d==expected: stay; prev<=d. If prev==9 and d==0, wrap_cnt<=wrap_cnt+1, saturating at 2^CNT_W-1.
  - legal and d!=expected: seq_err<=1, go to HUNT, seq_locked<=0, good_cnt<=0, prev<=d, have_prev<=1.
  - Illegal: seq_err<=1 and code_err<=1 in the same cycle; go to HUNT, seq_locked<=0, good_cnt<=0, have_prev<=0.
- wrap_cnt is cleared only by reset and holds across loss of lock.
- Repeated identical digits (d==prev) count as a mismatch.
- Two-state FSM; HUNT is the encoding default; unreachable encodings return to HUNT.

Test Plan:
- Reset then stream e=3,4,5,6 (in_valid=1 each cycle): q=0,1,2,3 one cycle later, out_valid high 4 cycles. seq_locked rises on the cycle after e=6 is sampled (3 good steps, LOCK_CNT=3). code_err=0 throughout.
- Locked, stream e=11,12,3,4 (digits 8,9,0,1): wrap_cnt 0->1 on the cycle after e=3 is sampled. seq_locked stays 1; seq_err=0.
- Locked at digit 4 (e=7), inject e=10 (digit 7): q=7 and seq_err=1 for one cycle. seq_locked falls to 0 the same cycle. Relock requires digits 8,9,0 (e=11,12,3).
- Locked, inject e=14: code_err=1, seq_err=1, out_valid=0, q unchanged, seq_locked=0. Then e=13 also gives code_err=1 with seq_err=0.
- in_valid toggling 1,0,1 with e=5 then e=6: output pulses only on valid cycles. The gap does not break the sequence (good_cnt advances).
- Assert rst_n=0 between clock edges while locked with wrap_cnt=2: all outputs go to 0 immediately, without waiting for a clock edge. After release, stream e=8 -> q=5, seq_locked=0.
